rsa_core_arbiter: RTL and testbench

//  Shares one Rsa256Core between NUM_REQ requesters (e.g. RS232 wrapper, debug/test port).

---
 rtl/rsa_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/rsa_core_arbiter.sv | 146 ++++++++++++++
 tb/tb_rsa_core_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_arb_pkg.sv
// Shared state encoding, defaults and index helper for the RSA core arbiter.
package rsa_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ABORT,
    S_RESP
  } arb_state_e;

  localparam int unsigned DEF_WIDTH   = 256;
  localparam int unsigned DEF_TIMEOUT = 262143;
  localparam int unsigned DEF_TO_W    = 18;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    // Scan from the farthest offset back to ptr so the nearest request overwrites last.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= int'(NUM_REQ)) c = c - int'(NUM_REQ);
      ci = IDX_W'(c);
      if (req[ci]) begin
        gnt     = '0;
        gnt[ci] = 1'b1;
        idx     = ci;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Shares one Rsa256Core between NUM_REQ requesters: round-robin grant, operand latch,
// start pulse, result capture and a watchdog that resets a hung core.
module rsa_core_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TO_W    = DEF_TO_W,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_d,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_n,
  output logic [NUM_REQ-1:0]         o_rsp_valid,
  input  logic [NUM_REQ-1:0]         i_rsp_ready,
  output logic [WIDTH-1:0]           o_rsp_data,
  output logic                       o_rsp_err,
  output logic                       o_core_start,
  output logic [WIDTH-1:0]           o_core_a,
  output logic [WIDTH-1:0]           o_core_d,
  output logic [WIDTH-1:0]           o_core_n,
  input  logic [WIDTH-1:0]           i_core_result,
  input  logic                       i_core_finished,
  output logic                       o_core_rst_n,
  output logic                       o_busy,
  output logic [IDX_W-1:0]           o_owner
);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [WIDTH-1:0]   a_q, d_q, n_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               core_rst_n_q;
  logic [TO_W-1:0]    wd_q;
  logic [TO_W-1:0]    wd_inc;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [WIDTH-1:0]   sel_a, sel_d, sel_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (i_req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_a = '0;
    sel_d = '0;
    sel_n = '0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if (gnt[r]) begin
        sel_a = i_req_a[r*WIDTH +: WIDTH];
        sel_d = i_req_d[r*WIDTH +: WIDTH];
        sel_n = i_req_n[r*WIDTH +: WIDTH];
      end
    end
  end

  assign wd_inc = wd_q + TO_W'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      a_q          <= '0;
      d_q          <= '0;
      n_q          <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      core_rst_n_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Ready equals the grant in this state, so any grant is a transfer.
          if (gnt_any) begin
            a_q     <= sel_a;
            d_q     <= sel_d;
            n_q     <= sel_n;
            owner_q <= gnt_idx;
            ptr_q   <= IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
            state_q <= S_START;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wd_q <= wd_inc;
          // A finish landing on the timeout cycle still counts as a normal completion.
          if (i_core_finished) begin
            rsp_data_q <= i_core_result;
            rsp_err_q  <= 1'b0;
            state_q    <= S_RESP;
          end else if (wd_inc == TO_W'(TIMEOUT)) begin
            core_rst_n_q <= 1'b0;
            state_q      <= S_ABORT;
          end
        end
        S_ABORT: begin
          core_rst_n_q <= 1'b1;
          rsp_data_q   <= '0;
          rsp_err_q    <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready[owner_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (state_q == S_RESP) o_rsp_valid[owner_q] = 1'b1;
  end

  assign o_req_ready  = (state_q == S_IDLE) ? gnt : '0;
  assign o_core_start = (state_q == S_START);
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_core_a     = a_q;
  assign o_core_d     = d_q;
  assign o_core_n     = n_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_owner      = owner_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter with a programmable-latency stub core and a modexp reference.
module tb_rsa_core_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 100;
  localparam int unsigned TOW = 7;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_d, req_n;
  logic [W-1:0]   rsp_data, core_a, core_d, core_n, core_result;
  logic           rsp_err, core_start, core_finished, core_rst_n, busy;
  logic [1:0]     owner;

  int checks   = 0;
  int failures = 0;
  int rr_ptr   = 0;

  int         stub_lat  = 1;
  int         stub_cnt  = 0;
  logic       stub_fin  = 1'b0;
  logic [W-1:0] stub_res = '0;
  logic       stray_fin = 1'b0;

  always #5 i_clk = ~i_clk;

  rsa_core_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .TIMEOUT (TMO),
    .TO_W    (TOW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_a         (req_a),
    .i_req_d         (req_d),
    .i_req_n         (req_n),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_core_start    (core_start),
    .o_core_a        (core_a),
    .o_core_d        (core_d),
    .o_core_n        (core_n),
    .i_core_result   (core_result),
    .i_core_finished (core_finished),
    .o_core_rst_n    (core_rst_n),
    .o_busy          (busy),
    .o_owner         (owner)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d,
                                          input logic [W-1:0] n);
    longint unsigned r, b, m;
    if (n == '0) return '0;
    m = {32'b0, n};
    b = {32'b0, a} % m;
    r = 64'd1 % m;
    for (int i = 0; i < int'(W); i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return W'(r);
  endfunction

  function automatic int winner(input logic [N-1:0] pat, input int ptr);
    for (int i = 0; i < int'(N); i++) begin
      if (pat[(ptr + i) % int'(N)]) return (ptr + i) % int'(N);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  // Stub core: finished pulses stub_lat cycles after the start cycle; 0 means never.
  assign core_finished = stub_fin | stray_fin;
  assign core_result   = stub_fin ? stub_res : '0;

  always @(posedge i_clk) begin
    stub_fin <= 1'b0;
    if (core_start) begin
      if (stub_lat == 1) begin
        stub_fin <= 1'b1;
        stub_res <= modexp(core_a, core_d, core_n);
        stub_cnt <= 0;
      end else if (stub_lat > 1) begin
        stub_cnt <= stub_lat - 1;
      end else begin
        stub_cnt <= 0;
      end
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_fin <= 1'b1;
        stub_res <= modexp(core_a, core_d, core_n);
      end
    end
  end

  // Called at a negedge; returns at the negedge where a response is first visible.
  task automatic do_job(input int r, input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] n, input int lat,
                        output logic [N-1:0] rv, output logic [W-1:0] data, output logic err,
                        output int starts, output int start_cyc, output int rstn_low,
                        output int rstn_cyc, output int rsp_cyc);
    int k;
    int cyc;
    rv = '0; data = '0; err = 1'b0;
    starts = 0; start_cyc = -1; rstn_low = 0; rstn_cyc = -1; rsp_cyc = -1;
    stub_lat = lat;
    req_a[r*W +: W] = a;
    req_d[r*W +: W] = d;
    req_n[r*W +: W] = n;
    req_valid[r] = 1'b1;
    #1;
    k = 0;
    while (req_ready[r] !== 1'b1 && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (req_ready[r] !== 1'b1) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge i_clk);
    req_valid[r] = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (core_start === 1'b1) begin
        starts++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (core_rst_n === 1'b0) begin
        rstn_low++;
        if (rstn_cyc < 0) rstn_cyc = cyc;
      end
      if (rsp_valid !== '0) begin
        rv = rsp_valid; data = rsp_data; err = rsp_err; rsp_cyc = cyc;
        break;
      end
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic ack(input int r);
    rsp_ready[r] = 1'b1;
    @(negedge i_clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    rr_ptr = 0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_d = '0; req_n = '0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, core_start, core_rst_n, busy, owner} !==
        {3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {req_ready, rsp_valid, rsp_err, core_start, core_rst_n, busy, owner},
               {3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    end
    checks++;
    if ({rsp_data, core_a, core_d, core_n} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_data, core_a, core_d, core_n);
    end
    i_rst = 1'b1;
    rr_ptr = 0;
  endtask

  task automatic test_single_job();
    logic [N-1:0] rv; logic [W-1:0] data; logic err;
    int starts, sc, rl, rc, pc;
    do_job(0, 32'h2, 32'h3, 32'hD, 5, rv, data, err, starts, sc, rl, rc, pc);
    checks++;
    if ({rv, data, err} !== {3'b001, 32'h8, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp got=%b/%h/%b exp=001/00000008/0", rv, data, err);
    end
    checks++;
    if (starts !== 1 || sc !== 1 || rl !== 0) begin
      failures++;
      $display("FAIL single_start got=starts%0d@%0d rstlow%0d exp=starts1@1 rstlow0",
               starts, sc, rl);
    end
    checks++;
    if (pc !== 7) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=7", pc);
    end
    checks++;
    if ({core_a, core_d, core_n} !== {32'h2, 32'h3, 32'hD}) begin
      failures++;
      $display("FAIL single_operands got=%h/%h/%h exp=2/3/d", core_a, core_d, core_n);
    end
    ack(0);
    rr_ptr = 1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pats [6];
    logic [N-1:0] pat, rv;
    logic [W-1:0] ea [N], ed [N], en [N];
    logic [W-1:0] data;
    logic err;
    int w, starts, sc, rl, rc, pc;
    pats = '{3'b011, 3'b011, 3'b011, 3'b111, 3'b101, 3'b110};
    apply_reset();
    for (int it = 0; it < 14; it++) begin
      pat = (it < 6) ? pats[it] : N'($urandom_range(1, 7));
      for (int r = 0; r < int'(N); r++) begin
        en[r] = W'($urandom_range(2, 65535));
        ea[r] = W'($urandom);
        ed[r] = W'($urandom);
        req_a[r*W +: W] = ea[r];
        req_d[r*W +: W] = ed[r];
        req_n[r*W +: W] = en[r];
      end
      req_valid = pat;
      #1;
      w = winner(pat, rr_ptr);
      checks++;
      if (req_ready !== onehot(w)) begin
        failures++;
        $display("FAIL rr_grant it=%0d pat=%b got=%b exp=%b", it, pat, req_ready, onehot(w));
      end
      do_job(w, ea[w], ed[w], en[w], $urandom_range(1, 20), rv, data, err, starts, sc, rl,
             rc, pc);
      checks++;
      if ({rv, data, err} !== {onehot(w), modexp(ea[w], ed[w], en[w]), 1'b0}) begin
        failures++;
        $display("FAIL rr_rsp it=%0d got=%b/%h/%b exp=%b/%h/0", it, rv, data, err, onehot(w),
                 modexp(ea[w], ed[w], en[w]));
      end
      ack(w);
      rr_ptr = (w + 1) % int'(N);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rv; logic [W-1:0] data, a, d, n, exp; logic err;
    int starts, sc, rl, rc, pc;
    a = 32'h1234; d = 32'h55; n = 32'hFFF1;
    exp = modexp(a, d, n);
    do_job(2, a, d, n, 3, rv, data, err, starts, sc, rl, rc, pc);
    rr_ptr = 0;
    req_a[0 +: W] = 32'h7; req_d[0 +: W] = 32'h9; req_n[0 +: W] = 32'h65;
    req_valid[0] = 1'b1;
    rsp_ready = 3'b011;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      checks++;
      if ({rsp_valid, rsp_data, rsp_err, req_ready} !== {3'b100, exp, 1'b0, 3'b000}) begin
        failures++;
        $display("FAIL hold_stable c=%0d got=%b/%h/%b/%b exp=100/%h/0/000", c, rsp_valid,
                 rsp_data, rsp_err, req_ready, exp);
      end
    end
    rsp_ready = '0;
    ack(2);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL next_grant got=%b exp=001", req_ready);
    end
    do_job(0, 32'h7, 32'h9, 32'h65, 2, rv, data, err, starts, sc, rl, rc, pc);
    checks++;
    if ({rv, data, err} !== {3'b001, modexp(32'h7, 32'h9, 32'h65), 1'b0}) begin
      failures++;
      $display("FAIL back_to_back got=%b/%h/%b exp=001/%h/0", rv, data, err,
               modexp(32'h7, 32'h9, 32'h65));
    end
    ack(0);
    rr_ptr = 1;
  endtask

  task automatic test_timeout();
    logic [N-1:0] rv; logic [W-1:0] data; logic err;
    int starts, sc, rl, rc, pc;
    do_job(1, 32'h3, 32'h5, 32'h7, 0, rv, data, err, starts, sc, rl, rc, pc);
    checks++;
    if ({rv, data, err} !== {3'b010, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL abort_rsp got=%b/%h/%b exp=010/00000000/1", rv, data, err);
    end
    checks++;
    if (rl !== 1 || rc !== int'(TMO) + 2 || pc !== int'(TMO) + 3) begin
      failures++;
      $display("FAIL abort_timing got=low%0d@%0d rsp@%0d exp=low1@%0d rsp@%0d", rl, rc, pc,
               TMO + 2, TMO + 3);
    end
    checks++;
    if (core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL abort_rstn_release got=%b exp=1", core_rst_n);
    end
    ack(1);
    rr_ptr = 2;
    do_job(2, 32'h3, 32'h5, 32'h7, TMO + 1, rv, data, err, starts, sc, rl, rc, pc);
    checks++;
    if ({rv, data, err, rl} !== {3'b100, 32'h0, 1'b1, 32'sd1}) begin
      failures++;
      $display("FAIL late_finish got=%b/%h/%b/low%0d exp=100/00000000/1/low1", rv, data, err,
               rl);
    end
    ack(2);
    rr_ptr = 0;
  endtask

  task automatic test_finish_on_timeout();
    logic [N-1:0] rv; logic [W-1:0] data; logic err;
    int starts, sc, rl, rc, pc;
    do_job(0, 32'h11, 32'h1F, 32'h3FD, TMO, rv, data, err, starts, sc, rl, rc, pc);
    checks++;
    if ({rv, data, err} !== {3'b001, modexp(32'h11, 32'h1F, 32'h3FD), 1'b0}) begin
      failures++;
      $display("FAIL edge_rsp got=%b/%h/%b exp=001/%h/0", rv, data, err,
               modexp(32'h11, 32'h1F, 32'h3FD));
    end
    checks++;
    if (rl !== 0 || pc !== int'(TMO) + 2) begin
      failures++;
      $display("FAIL edge_timing got=low%0d rsp@%0d exp=low0 rsp@%0d", rl, pc, TMO + 2);
    end
    ack(0);
    rr_ptr = 1;
  endtask

  task automatic test_reset_mid_job();
    int bad;
    int w;
    stub_lat = 30;
    req_a[W +: W] = 32'h5; req_d[W +: W] = 32'h7; req_n[W +: W] = 32'h1F;
    req_valid = 3'b010;
    #1;
    w = winner(3'b010, rr_ptr);
    checks++;
    if (req_ready !== onehot(w)) begin
      failures++;
      $display("FAIL midrst_grant got=%b exp=%b", req_ready, onehot(w));
    end
    @(negedge i_clk);
    req_valid = '0;
    repeat (10) @(negedge i_clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got=%b exp=1", busy);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, core_start, core_rst_n, owner, core_a, rsp_err, rsp_data} !==
        {1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL midrst_values got=%b/%b/%b/%b/%0d/%h/%b/%h exp=0/000/0/1/0/0/0/0", busy,
               rsp_valid, core_start, core_rst_n, owner, core_a, rsp_err, rsp_data);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    rr_ptr = 0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    stray_fin = 1'b1;
    @(negedge i_clk);
    stray_fin = 1'b0;
    @(negedge i_clk);
    if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stray_finish got=%0d bad cycles exp=0", bad);
    end
    req_valid = 3'b011;
    #1;
    checks++;
    if (req_ready !== onehot(winner(3'b011, rr_ptr))) begin
      failures++;
      $display("FAIL ptr_after_reset got=%b exp=%b", req_ready, onehot(winner(3'b011, rr_ptr)));
    end
    req_valid = '0;
    @(negedge i_clk);
    checks++;
    if ({busy, core_a} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL dropped_valid got=%b/%h exp=0/00000000", busy, core_a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_finish_on_timeout();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
